// File: rtl/fwrisc_regfile_mp.sv
// Multi-read-port register file with a self-clearing init sequencer and optional write-to-read bypass.
// Latency: 1 cycle from raddr to rdata. Init takes DEPTH cycles after reset or clear.
// Backpressure: none. Writes arriving while init_busy is high are dropped.
module fwrisc_regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int N_READ     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_READ*ADDR_WIDTH-1:0] raddr,
    output logic [N_READ*DATA_WIDTH-1:0] rdata,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         wen,
    input  logic                         clear,
    output logic                         init_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];
    logic                    wr_eff;
    logic [ADDR_WIDTH-1:0]   ra     [N_READ];
    logic [DATA_WIDTH-1:0]   rd_nxt [N_READ];
    logic [DATA_WIDTH-1:0]   rd_q   [N_READ];

    // A write is effective only in IDLE and never to a hardwired zero entry.
    assign wr_eff = (state == ST_IDLE) && wen && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state     <= ST_IDLE;
                        init_busy <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        state     <= ST_INIT;
                        cnt       <= '0;
                        init_busy <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    cnt       <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // The array carries no reset; the sequencer zeroes it one entry per cycle.
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            regs[cnt] <= '0;
        end else if (wr_eff) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < N_READ; i++) begin
            ra[i]     = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rd_nxt[i] = regs[ra[i]];
            if ((ZERO_REG != 0) && (ra[i] == '0)) begin
                rd_nxt[i] = '0;
            end else if ((BYPASS != 0) && wr_eff && (waddr == ra[i])) begin
                rd_nxt[i] = wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_READ; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_READ; i++) begin
                rd_q[i] <= (state == ST_INIT) ? '0 : rd_nxt[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_READ; i++) begin
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd_q[i];
        end
    end

endmodule

// File: tb/tb_fwrisc_regfile_mp.sv
// Scoreboard bench: three regfile configurations (default, read-first, 4-port/16-bit/no-zero) share one stimulus stream,
// each checked every cycle against an array-based reference model.
module tb_fwrisc_regfile_mp;

    typedef struct packed {
        logic [2:0]             busy;
        logic [2:0][3:0][31:0]  rd;
    } sb_t;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen   = 1'b0;
    logic        clear = 1'b0;
    logic [5:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [5:0]  ra [4];

    logic [11:0] raddr_ab;
    logic [19:0] raddr_c;
    logic [63:0] rdata_a, rdata_b, rdata_c;
    logic        busy_a, busy_b, busy_c;

    logic [31:0] mem [3][64];
    logic        mbusy [3];
    int          mleft [3];
    sb_t         sbq [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    assign raddr_ab = {ra[1], ra[0]};
    assign raddr_c  = {ra[3][4:0], ra[2][4:0], ra[1][4:0], ra[0][4:0]};

    fwrisc_regfile_mp u_a (
        .clock(clock), .reset(rst_n), .raddr(raddr_ab), .rdata(rdata_a),
        .waddr(waddr), .wdata(wdata), .wen(wen), .clear(clear), .init_busy(busy_a)
    );

    fwrisc_regfile_mp #(.BYPASS(0)) u_b (
        .clock(clock), .reset(rst_n), .raddr(raddr_ab), .rdata(rdata_b),
        .waddr(waddr), .wdata(wdata), .wen(wen), .clear(clear), .init_busy(busy_b)
    );

    fwrisc_regfile_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .N_READ(4), .ZERO_REG(0)) u_c (
        .clock(clock), .reset(rst_n), .raddr(raddr_c), .rdata(rdata_c),
        .waddr(waddr[4:0]), .wdata(wdata[15:0]), .wen(wen), .clear(clear), .init_busy(busy_c)
    );

    task automatic check(input string nm, input int d, input int p, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d port%0d: got %h expected %h at %0t", nm, d, p, got, exp, $time);
        end
    endtask

    task automatic get_actual(input int d, output logic b, output logic [3:0][31:0] r);
        r = '0;
        case (d)
            0: begin b = busy_a; r[0] = rdata_a[31:0]; r[1] = rdata_a[63:32]; end
            1: begin b = busy_b; r[0] = rdata_b[31:0]; r[1] = rdata_b[63:32]; end
            default: begin
                b = busy_c;
                for (int i = 0; i < 4; i++) r[i] = {16'h0, rdata_c[i*16 +: 16]};
            end
        endcase
    endtask

    // Reference model: one call per rising edge, using the inputs driven for that edge.
    task automatic model_step(input int d, output logic busy_o, output logic [3:0][31:0] rd_o);
        int          dep, nr, wa, a;
        bit          zr, bp, we;
        logic [31:0] dmask, wd;
        dep   = (d == 2) ? 32 : 64;
        nr    = (d == 2) ? 4 : 2;
        zr    = (d != 2);
        bp    = (d != 1);
        dmask = (d == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        rd_o  = '0;
        if (!rst_n) begin
            mbusy[d] = 1'b1;
            mleft[d] = dep;
        end else if (mbusy[d]) begin
            mleft[d]--;
            if (mleft[d] == 0) begin
                mbusy[d] = 1'b0;
                for (int k = 0; k < 64; k++) mem[d][k] = '0;
            end
        end else begin
            wa = int'(waddr) % dep;
            wd = wdata & dmask;
            we = wen && !(zr && wa == 0);
            for (int i = 0; i < nr; i++) begin
                a = int'(ra[i]) % dep;
                if (zr && a == 0)             rd_o[i] = '0;
                else if (bp && we && wa == a) rd_o[i] = wd;
                else                          rd_o[i] = mem[d][a];
            end
            if (we) mem[d][wa] = wd;
            if (clear) begin
                mbusy[d] = 1'b1;
                mleft[d] = dep;
            end
        end
        busy_o = mbusy[d];
    endtask

    task automatic drive(input logic r, input logic w, input int wa, input logic [31:0] wd, input logic c,
                         input int a0, input int a1, input int a2, input int a3);
        sb_t               e;
        logic              b;
        logic [3:0][31:0]  r4;
        @(negedge clock);
        rst_n = r; wen = w; waddr = 6'(wa); wdata = wd; clear = c;
        ra[0] = 6'(a0); ra[1] = 6'(a1); ra[2] = 6'(a2); ra[3] = 6'(a3);
        e = '0;
        for (int d = 0; d < 3; d++) begin
            model_step(d, b, r4);
            e.busy[d] = b;
            e.rd[d]   = r4;
        end
        sbq.push_back(e);
    endtask

    function automatic int rand_addr();
        return ($urandom % 4 == 0) ? int'($urandom_range(63, 0)) : int'($urandom_range(7, 0));
    endfunction

    task automatic rd(input int a0, input int a1, input int a2, input int a3);
        drive(1'b1, 1'b0, 0, 32'h0, 1'b0, a0, a1, a2, a3);
    endtask

    task automatic idle();
        rd(rand_addr(), rand_addr(), rand_addr(), rand_addr());
    endtask

    task automatic rnd_cycle();
        logic w, c;
        int   wa;
        w  = 1'($urandom % 2);
        c  = ($urandom % 200 == 0);
        wa = rand_addr();
        drive(1'b1, w, wa, $urandom, c, rand_addr(), rand_addr(), rand_addr(), rand_addr());
    endtask

    // Monitor: rdata is presented every cycle, so each edge consumes one scoreboard entry.
    initial begin
        sb_t               e;
        logic              b;
        logic [3:0][31:0]  r4;
        forever begin
            @(posedge clock);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int d = 0; d < 3; d++) begin
                    get_actual(d, b, r4);
                    check("init_busy", d, 0, {31'h0, b}, {31'h0, e.busy[d]});
                    for (int i = 0; i < ((d == 2) ? 4 : 2); i++) begin
                        check("rdata", d, i, r4[i], e.rd[d][i]);
                    end
                end
            end
        end
    end

    initial begin
        logic              b;
        logic [3:0][31:0]  r4;
        for (int i = 0; i < 4; i++) ra[i] = '0;
        for (int d = 0; d < 3; d++) begin
            mbusy[d] = 1'b1;
            mleft[d] = 0;
            for (int k = 0; k < 64; k++) mem[d][k] = '0;
        end

        repeat (3) drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0, 0);
        repeat (70) idle();
        for (int i = 0; i < 64; i++) rd(i, 63 - i, i, (i + 17) % 64);

        drive(1'b1, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 0, 0, 0);
        rd(5, 0, 5, 0);
        rd(5, 5, 5, 5);
        drive(1'b1, 1'b1, 0, 32'h0000_1234, 1'b0, 1, 1, 1, 1);
        rd(0, 0, 0, 0);

        drive(1'b1, 1'b1, 7, 32'h0000_0011, 1'b0, 0, 0, 0, 0);
        drive(1'b1, 1'b1, 7, 32'hA5A5_A5A5, 1'b0, 7, 7, 7, 7);
        rd(7, 7, 7, 7);

        drive(1'b1, 1'b1, 0, 32'h0000_BEEF, 1'b0, 1, 1, 1, 1);
        rd(0, 0, 0, 0);

        drive(1'b1, 1'b1, 3, 32'h0000_00FF, 1'b0, 0, 0, 0, 0);
        drive(1'b1, 1'b1, 4, 32'h0000_0044, 1'b1, 3, 4, 3, 4);
        repeat (10) idle();
        drive(1'b1, 1'b1, 9, 32'h0000_0099, 1'b0, 9, 9, 9, 9);
        repeat (60) idle();
        rd(3, 4, 9, 3);
        rd(9, 3, 4, 9);

        repeat (1500) rnd_cycle();
        repeat (70) idle();

        // Asynchronous reset asserted between edges while INIT is in progress.
        drive(1'b1, 1'b0, 0, 32'h0, 1'b1, 1, 2, 3, 4);
        repeat (20) idle();
        @(posedge clock);
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            get_actual(d, b, r4);
            check("async_busy", d, 0, {31'h0, b}, 32'h1);
            for (int i = 0; i < ((d == 2) ? 4 : 2); i++) check("async_rdata", d, i, r4[i], 32'h0);
        end
        repeat (2) drive(1'b0, 1'b1, 5, 32'h5555_5555, 1'b0, 5, 5, 5, 5);
        repeat (70) idle();
        for (int i = 0; i < 64; i += 4) rd(i, i + 1, i + 2, i + 3);
        repeat (300) rnd_cycle();

        @(posedge clock);
        #2;
        check("sb_drain", 0, 0, sbq.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
